// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one read or write INCR burst per command,
// data streamed through valid/ready ports, completion flagged by a done pulse.
module axi_burst_master #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [ADDR_WD-1:0]     cmd_addr_i,
    input  logic [7:0]             cmd_len_i,

    input  logic [DATA_WD-1:0]     wr_data_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,

    output logic [DATA_WD-1:0]     rd_data_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,

    output logic                   done_o,
    output logic [1:0]             err_o,

    output logic                   m_axi_arvalid_o,
    output logic [ADDR_WD-1:0]     m_axi_araddr_o,
    output logic [7:0]             m_axi_arlen_o,
    output logic [2:0]             m_axi_arsize_o,
    output logic [1:0]             m_axi_arburst_o,
    input  logic                   m_axi_arready_i,

    input  logic                   m_axi_rvalid_i,
    input  logic [DATA_WD-1:0]     m_axi_rdata_i,
    input  logic [1:0]             m_axi_rresp_i,
    input  logic                   m_axi_rlast_i,
    output logic                   m_axi_rready_o,

    output logic                   m_axi_awvalid_o,
    output logic [ADDR_WD-1:0]     m_axi_awaddr_o,
    output logic [7:0]             m_axi_awlen_o,
    output logic [2:0]             m_axi_awsize_o,
    output logic [1:0]             m_axi_awburst_o,
    input  logic                   m_axi_awready_i,

    output logic                   m_axi_wvalid_o,
    output logic [DATA_WD-1:0]     m_axi_wdata_o,
    output logic [DATA_WD/8-1:0]   m_axi_wstrb_o,
    output logic                   m_axi_wlast_o,
    input  logic                   m_axi_wready_i,

    input  logic                   m_axi_bvalid_i,
    input  logic [1:0]             m_axi_bresp_i,
    output logic                   m_axi_bready_o
);

    localparam int STRB_WD = DATA_WD / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WD));
    localparam logic [1:0] INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B
    } state_e;

    state_e             state_q;
    logic [ADDR_WD-1:0] addr_q;
    logic [7:0]         len_q;
    logic [8:0]         cnt_q;
    logic [1:0]         err_q;
    logic               done_q;

    logic last_beat;
    logic r_hs;
    logic w_hs;

    assign last_beat = (cnt_q == {1'b0, len_q});
    assign r_hs = (state_q == S_R) && m_axi_rvalid_i && rd_ready_i;
    assign w_hs = (state_q == S_W) && wr_valid_i && m_axi_wready_i;

    assign cmd_ready_o = (state_q == S_IDLE);
    assign done_o = done_q;
    assign err_o = err_q;

    assign m_axi_arvalid_o = (state_q == S_AR);
    assign m_axi_araddr_o = addr_q;
    assign m_axi_arlen_o = len_q;
    assign m_axi_arsize_o = AXSIZE;
    assign m_axi_arburst_o = INCR;

    // Read data is a straight pass-through while the burst is open
    assign m_axi_rready_o = (state_q == S_R) && rd_ready_i;
    assign rd_valid_o = (state_q == S_R) && m_axi_rvalid_i;
    assign rd_data_o = m_axi_rdata_i;

    assign m_axi_awvalid_o = (state_q == S_AW);
    assign m_axi_awaddr_o = addr_q;
    assign m_axi_awlen_o = len_q;
    assign m_axi_awsize_o = AXSIZE;
    assign m_axi_awburst_o = INCR;

    assign m_axi_wvalid_o = (state_q == S_W) && wr_valid_i;
    assign m_axi_wdata_o = wr_data_i;
    assign m_axi_wstrb_o = '1;
    assign m_axi_wlast_o = (state_q == S_W) && last_beat;
    assign wr_ready_o = (state_q == S_W) && m_axi_wready_i;

    assign m_axi_bready_o = (state_q == S_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q  <= cmd_addr_i;
                        len_q   <= cmd_len_i;
                        cnt_q   <= '0;
                        err_q   <= '0;
                        state_q <= cmd_write_i ? S_AW : S_AR;
                    end
                end
                S_AR: begin
                    if (m_axi_arready_i) state_q <= S_R;
                end
                S_R: begin
                    if (r_hs) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (m_axi_rresp_i != 2'b00) err_q[0] <= 1'b1;
                        // The beat count, not RLAST, ends the burst
                        if (m_axi_rlast_i != last_beat) err_q[1] <= 1'b1;
                        if (last_beat) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_AW: begin
                    if (m_axi_awready_i) state_q <= S_W;
                end
                S_W: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + 9'd1;
                        if (last_beat) state_q <= S_B;
                    end
                end
                S_B: begin
                    if (m_axi_bvalid_i) begin
                        if (m_axi_bresp_i != 2'b00) err_q[0] <= 1'b1;
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: acts as command source, data endpoints and AXI slave,
// with a scoreboard queue of data beats checked where they leave the DUT.
module tb_axi_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic        done;
    logic [1:0]  err;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rlast, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wlast, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_write_i(cmd_write), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .done_o(done), .err_o(err),
        .m_axi_arvalid_o(arvalid), .m_axi_araddr_o(araddr),
        .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
        .m_axi_arburst_o(arburst), .m_axi_arready_i(arready),
        .m_axi_rvalid_i(rvalid), .m_axi_rdata_i(rdata),
        .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast), .m_axi_rready_o(rready),
        .m_axi_awvalid_o(awvalid), .m_axi_awaddr_o(awaddr),
        .m_axi_awlen_o(awlen), .m_axi_awsize_o(awsize),
        .m_axi_awburst_o(awburst), .m_axi_awready_i(awready),
        .m_axi_wvalid_o(wvalid), .m_axi_wdata_o(wdata),
        .m_axi_wstrb_o(wstrb), .m_axi_wlast_o(wlast), .m_axi_wready_i(wready),
        .m_axi_bvalid_i(bvalid), .m_axi_bresp_i(bresp), .m_axi_bready_o(bready)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a command; with hold, cmd_valid stays up (other fields) while busy
    task automatic start_cmd(input bit wr, input logic [31:0] addr,
                             input logic [7:0] len, input bit hold);
        @(negedge clk);
        #1 chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        if (hold) begin
            cmd_write = ~wr;
            cmd_addr  = 32'h0000_DEA0;
            cmd_len   = 8'd9;
        end else begin
            cmd_valid = 1'b0;
        end
        #1 chk("cmd_ready_busy", cmd_ready, 1'b0);
    endtask

    task automatic addr_phase(input bit wr, input logic [31:0] addr,
                              input logic [7:0] len, input int delay);
        for (int k = 0; k <= delay; k++) begin
            if (wr) awready = (k == delay);
            else    arready = (k == delay);
            #1;
            chk(wr ? "awvalid" : "arvalid", wr ? awvalid : arvalid, 1'b1);
            chk(wr ? "awaddr" : "araddr", wr ? awaddr : araddr, addr);
            chk(wr ? "awlen" : "arlen", wr ? awlen : arlen, len);
            chk("axsize", wr ? awsize : arsize, 3'd2);
            chk("axburst", wr ? awburst : arburst, 2'b01);
            if (wr) chk("wvalid_before_aw", wvalid, 1'b0);
            @(negedge clk);
        end
        arready   = 1'b0;
        awready   = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic read_data(input int len, input bit toggle, input int bad_beat);
        int i = 0;
        int cyc = 0;
        bit pushed = 0;
        logic [31:0] exp;
        while (i <= len && cyc < 200) begin
            rvalid = 1'b1;
            if (!pushed) begin
                rdata = $urandom;
                sb.push_back(rdata);
                pushed = 1;
            end
            rlast    = (i == len) || (i == bad_beat);
            rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            chk("rready_follow", rready, rd_ready);
            chk("rd_valid", rd_valid, 1'b1);
            chk("done_mid_read", done, 1'b0);
            if (rd_valid && rd_ready) begin
                exp = sb.pop_front();
                chk("rd_data", rd_data, exp);
                i++;
                pushed = 0;
            end
            cyc++;
            @(negedge clk);
        end
        chk("read_beats", i, len + 1);
        rvalid   = 1'b0;
        rlast    = 1'b0;
        rd_ready = 1'b0;
    endtask

    task automatic write_data(input int len, input bit toggle, input int stop);
        int i = 0;
        int cyc = 0;
        bit pushed = 0;
        logic [31:0] exp;
        while (i <= len && i < stop && cyc < 200) begin
            wr_valid = 1'b1;
            if (!pushed) begin
                wr_data = $urandom;
                sb.push_back(wr_data);
                pushed = 1;
            end
            wready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            chk("wr_ready_follow", wr_ready, wready);
            if (wvalid && wready) begin
                exp = sb.pop_front();
                chk("wdata", wdata, exp);
                chk("wlast", wlast, i == len);
                chk("wstrb", wstrb, 4'hF);
                i++;
                pushed = 0;
            end
            cyc++;
            @(negedge clk);
        end
        chk("write_beats", i, (stop <= len) ? stop : len + 1);
        if (stop > len) begin
            wr_valid = 1'b0;
            wready   = 1'b0;
        end
    endtask

    task automatic resp_b(input int delay, input logic [1:0] resp);
        for (int k = 0; k <= delay; k++) begin
            bvalid = (k == delay);
            bresp  = resp;
            #1 chk("bready", bready, 1'b1);
            chk("done_before_b", done, 1'b0);
            @(negedge clk);
        end
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    task automatic check_done(input logic [1:0] exp_err);
        #1;
        chk("done_pulse", done, 1'b1);
        chk("err", err, exp_err);
        chk("cmd_ready_after", cmd_ready, 1'b1);
        chk("sb_empty", sb.size(), 0);
        @(negedge clk);
        #1 chk("done_once", done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_data = 0; wr_valid = 1; rd_ready = 1;
        arready = 0; rvalid = 1; rdata = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 1; bvalid = 0; bresp = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 2'b00);
        rst = 1'b0;
        wr_valid = 0; rvalid = 0; wready = 0; rd_ready = 0;

        // Read, late ARREADY, stray command held during the burst
        start_cmd(1'b0, 32'h100, 8'd3, 1'b1);
        addr_phase(1'b0, 32'h100, 8'd3, 2);
        read_data(3, 1'b0, -1);
        check_done(2'b00);

        // Single-beat write
        start_cmd(1'b1, 32'h200, 8'd0, 1'b0);
        addr_phase(1'b1, 32'h200, 8'd0, 0);
        write_data(0, 1'b0, 1000);
        resp_b(2, 2'b00);
        check_done(2'b00);

        // Read with consumer back-pressure
        start_cmd(1'b0, 32'h400, 8'd7, 1'b0);
        addr_phase(1'b0, 32'h400, 8'd7, 1);
        read_data(7, 1'b1, -1);
        check_done(2'b00);

        // Write with SLVERR response
        start_cmd(1'b1, 32'h800, 8'd3, 1'b0);
        addr_phase(1'b1, 32'h800, 8'd3, 1);
        write_data(3, 1'b1, 1000);
        resp_b(0, 2'b10);
        check_done(2'b01);

        // Early RLAST: status cleared from before, bit1 set, count-based end
        start_cmd(1'b0, 32'hC00, 8'd3, 1'b0);
        addr_phase(1'b0, 32'hC00, 8'd3, 0);
        read_data(3, 1'b0, 1);
        check_done(2'b10);

        // Reset in the middle of a write burst
        start_cmd(1'b1, 32'h1000, 8'd3, 1'b0);
        addr_phase(1'b1, 32'h1000, 8'd3, 0);
        write_data(3, 1'b0, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_wvalid", wvalid, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b1);
        chk("midrst_awvalid", awvalid, 1'b0);
        chk("midrst_err", err, 2'b00);
        chk("midrst_done", done, 1'b0);
        wr_valid = 1'b0;
        wready   = 1'b0;
        sb.delete();

        // Clean read after reset
        start_cmd(1'b0, 32'h2000, 8'd1, 1'b0);
        addr_phase(1'b0, 32'h2000, 8'd1, 0);
        read_data(1, 1'b0, -1);
        check_done(2'b00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
